// File: rtl/partition_sweep_checker.sv
// Exhaustive-sweep error checker: walks every NUM_PI-bit vector, compares exact vs approximate outputs.
// Define SWEEP_ERR_MAG_EN to enable max_abs_err / sum_abs_err; otherwise they read 0.
module partition_sweep_checker #(
    parameter int NUM_PI = 7,
    parameter int NUM_PO = 4,
    parameter int SETTLE = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    output logic [NUM_PI-1:0]          pi,
    input  logic [NUM_PO-1:0]          exact_po,
    input  logic [NUM_PO-1:0]          approx_po,
    output logic                       busy,
    output logic                       done,
    output logic [NUM_PI:0]            err_count,
    output logic [NUM_PI+4:0]          ham_sum,
    output logic [NUM_PO-1:0]          max_abs_err,
    output logic [NUM_PI+NUM_PO-1:0]   sum_abs_err
);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_SAMPLE, S_DONE} state_t;

    // With no settle time every vector is sampled in its first cycle.
    localparam state_t     VEC_STATE   = (SETTLE == 0) ? S_SAMPLE : S_HOLD;
    localparam logic [3:0] SETTLE_LAST = 4'((SETTLE == 0) ? 0 : SETTLE - 1);

    state_t                state_q;
    logic [NUM_PI-1:0]     pi_q;
    logic [3:0]            settle_q;
    logic                  busy_q;
    logic                  done_q;
    logic [NUM_PI:0]       err_q,  err_d;
    logic [NUM_PI+4:0]     ham_q,  ham_d;

    logic [NUM_PO-1:0]     diff;
    logic [4:0]            pop;

    assign diff = exact_po ^ approx_po;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_PO; i++) begin
            pop = pop + 5'(diff[i]);
        end
    end

    assign err_d = err_q + (NUM_PI+1)'(|diff);
    assign ham_d = ham_q + (NUM_PI+5)'(pop);

`ifdef SWEEP_ERR_MAG_EN
    logic [NUM_PO-1:0]        max_q, max_d;
    logic [NUM_PI+NUM_PO-1:0] sum_q, sum_d;
    logic [NUM_PO:0]          sub_full;
    logic [NUM_PO-1:0]        abs_err;

    // The extra top bit of the subtraction acts as the sign of exact - approx.
    assign sub_full = {1'b0, exact_po} - {1'b0, approx_po};
    assign abs_err  = sub_full[NUM_PO] ? (approx_po - exact_po) : sub_full[NUM_PO-1:0];
    assign max_d    = (abs_err > max_q) ? abs_err : max_q;
    assign sum_d    = sum_q + (NUM_PI+NUM_PO)'(abs_err);

    assign max_abs_err = max_q;
    assign sum_abs_err = sum_q;
`else
    assign max_abs_err = '0;
    assign sum_abs_err = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pi_q     <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= '0;
            ham_q    <= '0;
`ifdef SWEEP_ERR_MAG_EN
            max_q    <= '0;
            sum_q    <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start && !abort) begin
                        state_q  <= VEC_STATE;
                        pi_q     <= '0;
                        settle_q <= '0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        err_q    <= '0;
                        ham_q    <= '0;
`ifdef SWEEP_ERR_MAG_EN
                        max_q    <= '0;
                        sum_q    <= '0;
`endif
                    end
                end
                S_HOLD: begin
                    if (abort) begin
                        state_q  <= S_IDLE;
                        pi_q     <= '0;
                        settle_q <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b0;
                    end else if (settle_q == SETTLE_LAST) begin
                        state_q  <= S_SAMPLE;
                        settle_q <= '0;
                    end else begin
                        settle_q <= settle_q + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    // Aborting discards this cycle's comparison but keeps the partial totals.
                    if (abort) begin
                        state_q  <= S_IDLE;
                        pi_q     <= '0;
                        settle_q <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b0;
                    end else begin
                        err_q <= err_d;
                        ham_q <= ham_d;
`ifdef SWEEP_ERR_MAG_EN
                        max_q <= max_d;
                        sum_q <= sum_d;
`endif
                        if (pi_q == '1) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            pi_q    <= pi_q + NUM_PI'(1);
                            state_q <= VEC_STATE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign pi        = pi_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_count = err_q;
    assign ham_sum   = ham_q;

endmodule

// File: tb/tb_partition_sweep_checker.sv
// Bench for partition_sweep_checker: SETTLE=1 and SETTLE=0 instances driven by modelled partition pairs.
module tb_partition_sweep_checker;

    logic clk = 1'b0;
    logic rst;
    logic start_a, abort_a, start_b, abort_b;
    logic [6:0]  pi_a, pi_b;
    logic [3:0]  ex_a, ap_a, ex_b, ap_b;
    logic        busy_a, done_a, busy_b, done_b;
    logic [7:0]  err_a, err_b;
    logic [11:0] ham_a, ham_b;
    logic [3:0]  max_a, max_b;
    logic [10:0] sum_a, sum_b;

    int mode_a, mode_b;
    logic [3:0] rt_e [128];
    logic [3:0] rt_x [128];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int    mode;
        longint exp_err;
        longint exp_ham;
        longint exp_max;
        longint exp_sum;
    } vec_t;
    vec_t tbl [4];

    always #5 clk = ~clk;

    partition_sweep_checker #(.NUM_PI(7), .NUM_PO(4), .SETTLE(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .pi(pi_a),
        .exact_po(ex_a), .approx_po(ap_a), .busy(busy_a), .done(done_a),
        .err_count(err_a), .ham_sum(ham_a), .max_abs_err(max_a), .sum_abs_err(sum_a)
    );

    partition_sweep_checker #(.NUM_PI(7), .NUM_PO(4), .SETTLE(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .pi(pi_b),
        .exact_po(ex_b), .approx_po(ap_b), .busy(busy_b), .done(done_b),
        .err_count(err_b), .ham_sum(ham_b), .max_abs_err(max_b), .sum_abs_err(sum_b)
    );

    // Partition pairs: 0 identical, 1 LSB flipped, 2 approx stuck at zero, 3 random tables.
    function automatic logic [3:0] f_exact(int mode, logic [6:0] p);
        return (mode == 3) ? rt_e[p] : p[3:0];
    endfunction

    function automatic logic [3:0] f_approx(int mode, logic [6:0] p);
        case (mode)
            0:       return p[3:0];
            1:       return p[3:0] ^ 4'b0001;
            2:       return 4'b0000;
            default: return rt_x[p];
        endcase
    endfunction

    always_comb begin
        ex_a = f_exact(mode_a, pi_a);
        ap_a = f_approx(mode_a, pi_a);
        ex_b = f_exact(mode_b, pi_b);
        ap_b = f_approx(mode_b, pi_b);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference statistics over the first nvec vectors of the sweep.
    task automatic model(input int mode, input int nvec,
                         output longint e, output longint h, output longint m, output longint s);
        int ev, av, d;
        e = 0; h = 0; m = 0; s = 0;
        for (int v = 0; v < nvec; v++) begin
            ev = int'(f_exact(mode, 7'(v)));
            av = int'(f_approx(mode, 7'(v)));
            if (ev != av) e++;
            h += $countones(4'(ev ^ av));
            d = (ev > av) ? ev - av : av - ev;
            if (d > m) m = d;
            s += d;
        end
`ifndef SWEEP_ERR_MAG_EN
        m = 0; s = 0;
`endif
    endtask

    // Start dut_a, wait for done; lat = clock edges from the start edge to done.
    task automatic sweep_a(output int lat);
        int n;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        n = 1;
        chk("a_first_cycle_busy_pi", {busy_a, pi_a}, {1'b1, 7'd0});
        while (!done_a && n < 2000) begin
            @(negedge clk); n++;
        end
        lat = n - 1;
    endtask

    task automatic chk_results_a(input string tag, input longint e, input longint h,
                                 input longint m, input longint s);
        chk({tag, "_err"}, err_a, e);
        chk({tag, "_ham"}, ham_a, h);
        chk({tag, "_max"}, max_a, m);
        chk({tag, "_sum"}, sum_a, s);
        $display("sweep %s: err=%0d ham=%0d max=%0d sum=%0d", tag, err_a, ham_a, max_a, sum_a);
    endtask

    initial begin
        int lat, n, gaps;
        longint e, h, m, s;

        for (int i = 0; i < 128; i++) begin
            rt_e[i] = 4'($urandom);
            rt_x[i] = ($urandom_range(0, 2) == 0) ? rt_e[i] : 4'($urandom);
        end
        tbl[0] = '{0, 0,   0,   0,  0};
        tbl[1] = '{1, 128, 128, 1,  128};
        tbl[2] = '{2, 120, 256, 15, 960};
        model(3, 128, e, h, m, s);
        tbl[3] = '{3, e, h, m, s};
`ifndef SWEEP_ERR_MAG_EN
        for (int i = 0; i < 3; i++) begin
            tbl[i].exp_max = 0;
            tbl[i].exp_sum = 0;
        end
`endif

        mode_a = 0; mode_b = 0;
        start_a = 0; abort_a = 0; start_b = 0; abort_b = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state_a", {busy_a, done_a, pi_a, err_a, ham_a, max_a, sum_a}, 0);
        chk("reset_state_b", {busy_b, done_b, pi_b, err_b, ham_b, max_b, sum_b}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Full sweeps for each partition pair.
        for (int t = 0; t < 4; t++) begin
            mode_a = tbl[t].mode;
            sweep_a(lat);
            chk("a_done_latency", lat, 256);
            chk("a_busy_low_at_done", busy_a, 0);
            chk("a_pi_frozen", pi_a, 127);
            chk_results_a($sformatf("mode%0d", tbl[t].mode),
                          tbl[t].exp_err, tbl[t].exp_ham, tbl[t].exp_max, tbl[t].exp_sum);
        end

        // Results stay frozen in DONE.
        repeat (5) @(negedge clk);
        chk("a_done_hold", {done_a, busy_a, err_a}, {1'b1, 1'b0, 8'(tbl[3].exp_err)});

        // SETTLE=0: one vector per cycle, start mid-sweep ignored, pi contiguous.
        mode_b = 0;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        n = 1; gaps = 0;
        while (!done_b && n < 2000) begin
            if (!busy_b || pi_b != 7'(n - 1)) gaps++;
            if (n == 50) start_b = 1'b1;
            if (n == 51) start_b = 1'b0;
            @(negedge clk); n++;
        end
        chk("b_done_latency", n - 1, 128);
        chk("b_pi_sequence_gaps", gaps, 0);
        chk("b_identical_err", {err_b, ham_b, max_b, sum_b}, 0);
        $display("sweep b identical: latency=%0d gaps=%0d err=%0d", n - 1, gaps, err_b);

        mode_b = 3;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        n = 1;
        while (!done_b && n < 2000) begin
            @(negedge clk); n++;
        end
        chk("b_rand_latency", n - 1, 128);
        chk("b_rand_err", err_b, tbl[3].exp_err);
        chk("b_rand_ham", ham_b, tbl[3].exp_ham);
        chk("b_rand_max", max_b, tbl[3].exp_max);
        chk("b_rand_sum", sum_b, tbl[3].exp_sum);
        $display("sweep b random: err=%0d ham=%0d max=%0d sum=%0d", err_b, ham_b, max_b, sum_b);

        // Abort sampled on the SAMPLE cycle of vector 19: only vectors 0..18 count.
        mode_a = 2;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        n = 1;
        while (n < 40) begin
            @(negedge clk); n++;
        end
        abort_a = 1'b1;
        @(negedge clk); abort_a = 1'b0;
        chk("abort_idle", {busy_a, done_a, pi_a}, 0);
        model(2, 19, e, h, m, s);
        chk("abort_partial_err", err_a, e);
        chk("abort_partial_ham", ham_a, h);
        chk("abort_partial_sum", sum_a, s);
        $display("abort: busy=%0d done=%0d pi=%0d err=%0d ham=%0d", busy_a, done_a, pi_a, err_a, ham_a);
        repeat (3) @(negedge clk);
        chk("abort_stays_idle", {busy_a, done_a, pi_a}, 0);
        sweep_a(lat);
        chk("restart_latency", lat, 256);
        chk_results_a("restart", tbl[2].exp_err, tbl[2].exp_ham, tbl[2].exp_max, tbl[2].exp_sum);

        // Asynchronous reset mid-sweep.
        mode_a = 3;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        n = 1;
        while (n < 101) begin
            @(negedge clk); n++;
        end
        chk("pre_reset_busy", busy_a, 1);
        #2 rst = 1'b1;
        #1 chk("rst_async_outputs", {busy_a, done_a, pi_a, err_a, ham_a, max_a, sum_a}, 0);
        $display("reset mid-sweep: busy=%0d pi=%0d err=%0d", busy_a, pi_a, err_a);
        @(negedge clk); rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("post_reset_idle", {busy_a, done_a, pi_a, err_a}, 0);
        sweep_a(lat);
        chk("post_reset_latency", lat, 256);
        chk_results_a("post_reset", tbl[3].exp_err, tbl[3].exp_ham, tbl[3].exp_max, tbl[3].exp_sum);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
